// File: rtl/gf180mcu_ocd_io__asig_mux_ctrl.sv
// gf180mcu_ocd_io__asig_mux_ctrl
// Core-side sequencer for the 5V analog pad switch network. It connects one of
// NCH internal analog nets to the ASIG5V pad through one-hot switch enables.
// A change of channel always breaks before it makes: every switch stays open
// for DEAD_CYC cycles, and the new switch then settles for SETTLE_CYC cycles
// before the channel is reported as connected.
//
// Handshake: a request is taken on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE and CONN. While
// req_ready is low the requester holds req_valid, and nothing is consumed.
// req_sel and req_off are sampled only on the accept edge. Every accepted
// request ends with a single-cycle done pulse.
`timescale 1ns/1ps

module gf180mcu_ocd_io__asig_mux_ctrl #(
  parameter int NCH        = 4,
  parameter int DEAD_CYC   = 8,
  parameter int SETTLE_CYC = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [$clog2(NCH)-1:0] req_sel,
  input  logic                   req_off,
  output logic                   req_ready,
  output logic [NCH-1:0]         sw_en,
  output logic [$clog2(NCH)-1:0] cur_sel,
  output logic                   connected,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             fsm_state
);

  localparam int SW   = $clog2(NCH);
  localparam int MAXC = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  // Final count values: the state is left on the edge where the counter
  // holds its last value, so each timed state lasts exactly N cycles.
  localparam logic [CW-1:0] DEAD_LAST   = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  // IDLE : every switch open, nothing in progress
  // BREAK: every switch open, dead-time count running
  // MAKE : target switch closed, settle count running
  // CONN : target switch closed and settled
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_CONN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic [NCH-1:0]  sw_q, sw_d;
  logic            done_q, done_d;
  logic            off_q, off_d;     // the sequence in flight is a disconnect
  logic            accept;

  // One-hot decode of a channel index into a switch-enable pattern.
  function automatic logic [NCH-1:0] onehot(input logic [SW-1:0] s);
    logic [NCH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_CONN);
  assign accept    = req_valid && req_ready;

  // State, counter and all pad-facing outputs are registered. The async reset
  // opens every switch at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      sw_q    <= '0;
      done_q  <= 1'b0;
      off_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
      off_q   <= off_d;
    end
  end

  // Next-state, next switch pattern and completion pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    cur_d   = cur_q;
    sw_d    = sw_q;
    done_d  = 1'b0;
    off_d   = off_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sw_d  = '0;
        if (accept) begin
          if (req_off) begin
            // Already open: nothing to switch, complete at once.
            done_d = 1'b1;
          end else begin
            // Nothing to break from IDLE, so close the target immediately.
            off_d   = 1'b0;
            cur_d   = req_sel;
            sw_d    = onehot(req_sel);
            state_d = ST_MAKE;
          end
        end
      end

      ST_BREAK: begin
        sw_d = '0;
        if (cnt_q == DEAD_LAST) begin
          cnt_d = '0;
          if (off_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_MAKE;
            sw_d    = onehot(cur_q);
          end
        end
      end

      ST_MAKE: begin
        sw_d = onehot(cur_q);
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CONN;
          done_d  = 1'b1;
        end
      end

      ST_CONN: begin
        cnt_d = '0;
        sw_d  = onehot(cur_q);
        if (accept) begin
          if (req_off) begin
            // Disconnect: open on the accept edge, then wait out the dead time.
            sw_d    = '0;
            off_d   = 1'b1;
            state_d = ST_BREAK;
          end else if (req_sel != cur_q) begin
            // New channel: open now, close the new one only after the dead time.
            sw_d    = '0;
            off_d   = 1'b0;
            cur_d   = req_sel;
            state_d = ST_BREAK;
          end else begin
            // Same channel again: no switching, just acknowledge.
            done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sw_d    = '0;
      end
    endcase
  end

  assign sw_en     = sw_q;
  assign cur_sel   = cur_q;
  assign done      = done_q;
  assign connected = (state_q == ST_CONN);
  assign busy      = (state_q == ST_BREAK) || (state_q == ST_MAKE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__asig_mux_ctrl.sv
// Self-checking bench for gf180mcu_ocd_io__asig_mux_ctrl.
// The reference model tracks only "which channel is connected" and derives
// each request's expected waveform from the break/make timing rules.
`timescale 1ns/1ps

module tb_gf180mcu_ocd_io__asig_mux_ctrl;

  localparam int NCH    = 4;
  localparam int SW     = 2;
  localparam int DEAD   = 8;
  localparam int SETTLE = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic [SW-1:0]  req_sel;
  logic           req_off;
  logic           req_ready;
  logic [NCH-1:0] sw_en;
  logic [SW-1:0]  cur_sel;
  logic           connected;
  logic           busy;
  logic           done;
  logic [1:0]     fsm_state;

  int checks = 0;
  int errors = 0;

  // Reference model: is a channel connected, and which one.
  bit m_conn;
  int m_cur;

  gf180mcu_ocd_io__asig_mux_ctrl #(
    .NCH(NCH), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sel(req_sel), .req_off(req_off),
    .req_ready(req_ready), .sw_en(sw_en), .cur_sel(cur_sel),
    .connected(connected), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int oh(input int ch);
    return 1 << ch;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_sw, input bit e_busy,
                            input bit e_conn, input bit e_done, input bit e_rdy,
                            input int e_cur);
    chk({tag, ".sw_en"},     32'(sw_en),     32'(e_sw));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    chk({tag, ".connected"}, 32'(connected), 32'(e_conn));
    chk({tag, ".done"},      32'(done),      32'(e_done));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_rdy));
    chk({tag, ".cur_sel"},   32'(cur_sel),   32'(e_cur));
  endtask

  // Quiet cycles: outputs hold the model's steady state, no done pulse.
  task automatic idle_cycles(input int n, input string tag);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outs($sformatf("%s idle%0d", tag, i),
                 m_conn ? oh(m_cur) : 0, 1'b0, m_conn, 1'b0, 1'b1, m_cur);
    end
  endtask

  // One request, called at a negedge with the controller ready. Checks every
  // cycle from the accept edge (k=0) to the done pulse (k=T). With hold=1 a
  // follow-up request (hsel/hoff) is kept valid through the whole sequence.
  task automatic run_txn(input int sel, input bit off, input bit hold,
                         input int hsel, input bit hoff, input string tag);
    int brk, mk, tot, new_cur, e_sw;
    bit new_conn;
    brk      = (m_conn && (off || sel != m_cur)) ? DEAD : 0;
    mk       = (!off && (!m_conn || sel != m_cur)) ? SETTLE : 0;
    tot      = brk + mk;
    new_cur  = off ? m_cur : sel;
    new_conn = !off;

    req_valid = 1'b1;
    req_sel   = SW'(sel);
    req_off   = off;
    chk({tag, " ready_before_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k <= tot; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) begin
          req_sel = SW'(hsel);
          req_off = hoff;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (k < tot) begin
        e_sw = (k < brk) ? 0 : oh(new_cur);
        check_outs($sformatf("%s k=%0d", tag, k), e_sw, 1'b1, 1'b0, 1'b0, 1'b0, new_cur);
      end else begin
        check_outs($sformatf("%s done k=%0d", tag, k),
                   new_conn ? oh(new_cur) : 0, 1'b0, new_conn, 1'b1, 1'b1, new_cur);
      end
    end
    m_conn = new_conn;
    m_cur  = new_cur;
  endtask

  initial begin
    int sel;
    bit off;

    // Reset
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    req_off   = 1'b0;
    m_conn    = 1'b0;
    m_cur     = 0;
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rst = 1'b0;
    idle_cycles(2, "post_reset");

    // Directed sequence
    run_txn(2, 1'b0, 1'b0, 0, 1'b0, "idle_to_ch2");
    run_txn(1, 1'b0, 1'b0, 0, 1'b0, "ch2_to_ch1");
    run_txn(1, 1'b0, 1'b0, 0, 1'b0, "ch1_same");
    idle_cycles(3, "after_same");
    run_txn(0, 1'b1, 1'b0, 0, 1'b0, "off_from_conn");
    idle_cycles(2, "after_off");
    run_txn(3, 1'b1, 1'b0, 0, 1'b0, "off_from_idle");
    run_txn(3, 1'b0, 1'b1, 0, 1'b0, "make_with_held_req");
    run_txn(0, 1'b0, 1'b0, 0, 1'b0, "held_req_taken");
    idle_cycles(4, "held_req_once");

    // Reset pulse between clock edges in the middle of MAKE
    run_txn(0, 1'b1, 1'b0, 0, 1'b0, "open_before_rst");
    req_valid = 1'b1;
    req_sel   = 2'd3;
    req_off   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_outs("rst_mid_make pre", oh(3), 1'b1, 1'b0, 1'b0, 1'b0, 3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_outs("rst_mid_make async", 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    check_outs("rst_mid_make held", 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    rst    = 1'b0;
    m_conn = 1'b0;
    m_cur  = 0;
    idle_cycles(2, "after_rst");

    // Randomized requests against the model
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, NCH - 1);
      off = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), $sformatf("rnd%0d", n));
      run_txn(sel, off, 1'b0, 0, 1'b0, $sformatf("rnd%0d sel=%0d off=%0d", n, sel, off));
    end
    idle_cycles(2, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
